clock_mode_ctrl: RTL and testbench

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

---
 rtl/clock_pkg.sv | 23 ++
 rtl/wrap_inc.sv | 21 ++
 rtl/clock_mode_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock mode controller:
//   state_e     - controller states; the encoding is what the display sees on `mode`
//   HOURS_MAX   - last legal hour value (wraps to 0 after it)
//   MINUTES_MAX - last legal minute value (wraps to 0 after it)
//   HOUR_W      - bit width of an hours field
//   MIN_W       - bit width of a minutes field
package clock_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        LOAD    = 3'd3,
        AL_HR   = 3'd4,
        AL_MIN  = 3'd5
    } state_e;

    localparam int HOURS_MAX   = 23;
    localparam int MINUTES_MAX = 59;
    localparam int HOUR_W      = 5;
    localparam int MIN_W       = 6;

endpackage

// File: rtl/wrap_inc.sv
// Modulo incrementer: next_o = value_i + 1, wrapping to 0 once value_i
// reaches MAX (out-of-range values also wrap to 0).
//   value_i : current value, W bits
//   next_o  : incremented value, W bits
module wrap_inc #(
    parameter int W   = 5,
    parameter int MAX = 23
) (
    input  logic [W-1:0] value_i,
    output logic [W-1:0] next_o
);

    always_comb begin
        if (value_i >= W'(MAX)) begin
            next_o = '0;
        end else begin
            next_o = value_i + W'(1);
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button-driven mode controller for an alarm clock. Lets the user set the
// running time (loaded into the timekeeper with a one-cycle strobe) and the
// alarm time, arms/disarms the alarm, and drives the alarm ringer.
//   clk, rst                   : clock, asynchronous active-high reset
//   btn_mode, btn_set, btn_inc : debounced one-cycle button pulses
//   cur_hours, cur_minutes     : running time from the timekeeper
//   set_time_flag              : timekeeper load strobe
//   set_hours, set_minutes     : load value (always the edit registers)
//   alarm_hours, alarm_minutes : committed alarm time
//   alarm_en, alarm_ring       : alarm armed / alarm sounding
//   mode                       : current state, for the display
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT  = 30,
    parameter int RING_LEN = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_set,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    output logic              set_time_flag,
    output logic [HOUR_W-1:0] set_hours,
    output logic [MIN_W-1:0]  set_minutes,
    output logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0]  alarm_minutes,
    output logic              alarm_en,
    output logic              alarm_ring,
    output logic [2:0]        mode
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int RING_W = $clog2(RING_LEN + 1);

    state_e            state_q, state_d;
    logic [HOUR_W-1:0] edit_h_q, edit_h_d, alarm_h_q, alarm_h_d, edit_h_inc;
    logic [MIN_W-1:0]  edit_m_q, edit_m_d, alarm_m_q, alarm_m_d, edit_m_inc;
    logic              alarm_en_q, alarm_en_d;
    logic              ring_q, ring_d;
    logic              match_q, match_d;
    logic              flag_q;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic              any_btn, take_mode, take_set, take_inc, in_edit, rise;

    wrap_inc #(.W(HOUR_W), .MAX(HOURS_MAX)) u_inc_h (
        .value_i (edit_h_q),
        .next_o  (edit_h_inc)
    );

    wrap_inc #(.W(MIN_W), .MAX(MINUTES_MAX)) u_inc_m (
        .value_i (edit_m_q),
        .next_o  (edit_m_inc)
    );

    always_comb begin
        any_btn   = btn_mode | btn_set | btn_inc;
        // While ringing, every pulse is swallowed by the silence action.
        take_mode = !ring_q && btn_mode;
        take_set  = !ring_q && !btn_mode && btn_set;
        take_inc  = !ring_q && !btn_mode && !btn_set && btn_inc;
        in_edit   = (state_q == SET_HR) || (state_q == SET_MIN) ||
                    (state_q == AL_HR)  || (state_q == AL_MIN);
        match_d   = alarm_en_q && (cur_hours == alarm_h_q) && (cur_minutes == alarm_m_q);
        rise      = match_d && !match_q;

        state_d    = state_q;
        edit_h_d   = edit_h_q;
        edit_m_d   = edit_m_q;
        alarm_h_d  = alarm_h_q;
        alarm_m_d  = alarm_m_q;
        alarm_en_d = alarm_en_q;
        idle_d     = '0;

        case (state_q)
            RUN: begin
                if (take_mode) begin
                    state_d  = SET_HR;
                    edit_h_d = cur_hours;
                    edit_m_d = cur_minutes;
                end else if (take_set) begin
                    state_d  = AL_HR;
                    edit_h_d = alarm_h_q;
                    edit_m_d = alarm_m_q;
                end else if (take_inc) begin
                    alarm_en_d = !alarm_en_q;
                end
            end
            SET_HR, AL_HR: begin
                if (take_mode) begin
                    state_d = (state_q == SET_HR) ? SET_MIN : AL_MIN;
                end else if (take_inc) begin
                    edit_h_d = edit_h_inc;
                end
            end
            SET_MIN: begin
                if (take_mode) begin
                    state_d = LOAD;
                end else if (take_inc) begin
                    edit_m_d = edit_m_inc;
                end
            end
            AL_MIN: begin
                if (take_mode) begin
                    state_d    = RUN;
                    alarm_h_d  = edit_h_q;
                    alarm_m_d  = edit_m_q;
                    alarm_en_d = 1'b1;
                end else if (take_inc) begin
                    edit_m_d = edit_m_inc;
                end
            end
            LOAD:    state_d = RUN;
            default: state_d = RUN;
        endcase

        // btn_set is ignored in edit states, so it does not count as activity.
        if (in_edit && !take_mode && !take_inc) begin
            if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                state_d = RUN;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end

        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (ring_q) begin
            if (any_btn || (ring_cnt_q == RING_W'(RING_LEN - 1))) begin
                ring_d = 1'b0;
            end else begin
                ring_cnt_d = ring_cnt_q + RING_W'(1);
            end
        end
        // A fresh match edge (re)starts the ring period.
        if (rise) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end
        if (!alarm_en_d) begin
            ring_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            edit_h_q   <= '0;
            edit_m_q   <= '0;
            alarm_h_q  <= '0;
            alarm_m_q  <= '0;
            alarm_en_q <= 1'b0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
            idle_q     <= '0;
            match_q    <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edit_h_q   <= edit_h_d;
            edit_m_q   <= edit_m_d;
            alarm_h_q  <= alarm_h_d;
            alarm_m_q  <= alarm_m_d;
            alarm_en_q <= alarm_en_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
            idle_q     <= idle_d;
            match_q    <= match_d;
            // Registered copy of "state is LOAD" so the strobe comes from a flop.
            flag_q     <= (state_d == LOAD);
        end
    end

    assign set_time_flag = flag_q;
    assign set_hours     = edit_h_q;
    assign set_minutes   = edit_m_q;
    assign alarm_hours   = alarm_h_q;
    assign alarm_minutes = alarm_m_q;
    assign alarm_en      = alarm_en_q;
    assign alarm_ring    = ring_q;
    assign mode          = state_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
module tb_clock_mode_ctrl;
    import clock_pkg::*;

    localparam int TIMEOUT  = 30;
    localparam int RING_LEN = 60;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_set, btn_inc;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       set_time_flag;
    logic [4:0] set_hours, alarm_hours;
    logic [5:0] set_minutes, alarm_minutes;
    logic       alarm_en, alarm_ring;
    logic [2:0] mode;

    clock_mode_ctrl #(.TIMEOUT(TIMEOUT), .RING_LEN(RING_LEN)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .set_time_flag(set_time_flag),
        .set_hours(set_hours), .set_minutes(set_minutes), .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes), .alarm_en(alarm_en), .alarm_ring(alarm_ring), .mode(mode)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: times as plain integers, ring tracked as cycles rung so far.
    state_e m_mode;
    int     m_eh, m_em, m_ah, m_am, m_idle, m_rung;
    bit     m_en, m_ring, m_prev, m_flag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = RUN;
        m_eh = 0; m_em = 0; m_ah = 0; m_am = 0; m_idle = 0; m_rung = 0;
        m_en = 0; m_ring = 0; m_prev = 0; m_flag = 0;
    endtask

    task automatic model_step(input bit bm, input bit bs, input bit bi, input int ch, input int cm);
        bit     hit, rise, editing;
        int     pick;
        state_e nmode;
        int     neh, nem, nah, nam, nidle, nrung;
        bit     nen, nring;
        hit   = m_en && (ch * 60 + cm == m_ah * 60 + m_am);
        rise  = hit && !m_prev;
        pick  = 0;  // 0 none, 1 mode, 2 set, 3 inc
        if (!m_ring) pick = bm ? 1 : (bs ? 2 : (bi ? 3 : 0));
        nmode = m_mode; neh = m_eh; nem = m_em; nah = m_ah; nam = m_am; nen = m_en;
        nring = m_ring; nrung = m_rung; nidle = 0;
        case (m_mode)
            RUN: begin
                if (pick == 1) begin nmode = SET_HR; neh = ch; nem = cm; end
                else if (pick == 2) begin nmode = AL_HR; neh = m_ah; nem = m_am; end
                else if (pick == 3) nen = !m_en;
            end
            SET_HR, AL_HR: begin
                if (pick == 1) nmode = (m_mode == SET_HR) ? SET_MIN : AL_MIN;
                else if (pick == 3) neh = (m_eh + 1) % 24;
            end
            SET_MIN, AL_MIN: begin
                if (pick == 1) begin
                    if (m_mode == SET_MIN) nmode = LOAD;
                    else begin nmode = RUN; nah = m_eh; nam = m_em; nen = 1; end
                end else if (pick == 3) nem = (m_em + 1) % 60;
            end
            default: nmode = RUN;
        endcase
        editing = (m_mode != RUN) && (m_mode != LOAD);
        if (editing && pick != 1 && pick != 3) begin
            if (m_idle + 1 >= TIMEOUT) nmode = RUN;
            else nidle = m_idle + 1;
        end
        if (m_ring) begin
            if (bm || bs || bi || m_rung >= RING_LEN) nring = 0;
            else nrung = m_rung + 1;
        end
        if (rise) begin nring = 1; nrung = 1; end
        if (!nen) nring = 0;
        m_mode = nmode; m_eh = neh; m_em = nem; m_ah = nah; m_am = nam; m_en = nen;
        m_ring = nring; m_rung = nrung; m_idle = nidle; m_prev = hit;
        m_flag = (nmode == LOAD);
    endtask

    task automatic cycle(input bit bm, input bit bs, input bit bi);
        btn_mode = bm; btn_set = bs; btn_inc = bi;
        @(posedge clk);
        model_step(bm, bs, bi, int'(cur_hours), int'(cur_minutes));
        @(negedge clk);
        btn_mode = 0; btn_set = 0; btn_inc = 0;
    endtask

    task automatic check_model(input int n);
        check($sformatf("rnd%0d.mode", n), 32'(mode), 32'(m_mode));
        check($sformatf("rnd%0d.flag", n), 32'(set_time_flag), 32'(m_flag));
        check($sformatf("rnd%0d.set_h", n), 32'(set_hours), 32'(m_eh));
        check($sformatf("rnd%0d.set_m", n), 32'(set_minutes), 32'(m_em));
        check($sformatf("rnd%0d.al_h", n), 32'(alarm_hours), 32'(m_ah));
        check($sformatf("rnd%0d.al_m", n), 32'(alarm_minutes), 32'(m_am));
        check($sformatf("rnd%0d.en", n), 32'(alarm_en), 32'(m_en));
        check($sformatf("rnd%0d.ring", n), 32'(alarm_ring), 32'(m_ring));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mode"}, 32'(mode), 32'(RUN));
        check({tag, ".flag"}, 32'(set_time_flag), 0);
        check({tag, ".set_h"}, 32'(set_hours), 0);
        check({tag, ".set_m"}, 32'(set_minutes), 0);
        check({tag, ".al_h"}, 32'(alarm_hours), 0);
        check({tag, ".al_m"}, 32'(alarm_minutes), 0);
        check({tag, ".en"}, 32'(alarm_en), 0);
        check({tag, ".ring"}, 32'(alarm_ring), 0);
    endtask

    typedef struct {
        bit bm, bs, bi;
        int exp_mode;
        bit exp_flag;
        int exp_h, exp_m;
        bit exp_en;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int ring_cnt, flag_seen, dens, sel;
        bit ring_at_61;

        // Time set 10:58 -> 13:00, then priority and toggle checks (cur fixed at 10:58).
        vecs[0]  = '{1, 0, 0, int'(SET_HR),  0, 10, 58, 0};
        vecs[1]  = '{0, 0, 1, int'(SET_HR),  0, 11, 58, 0};
        vecs[2]  = '{0, 0, 1, int'(SET_HR),  0, 12, 58, 0};
        vecs[3]  = '{0, 0, 1, int'(SET_HR),  0, 13, 58, 0};
        vecs[4]  = '{1, 0, 0, int'(SET_MIN), 0, 13, 58, 0};
        vecs[5]  = '{0, 0, 1, int'(SET_MIN), 0, 13, 59, 0};
        vecs[6]  = '{0, 0, 1, int'(SET_MIN), 0, 13, 0,  0};
        vecs[7]  = '{1, 0, 0, int'(LOAD),    1, 13, 0,  0};
        vecs[8]  = '{0, 0, 0, int'(RUN),     0, 13, 0,  0};
        vecs[9]  = '{1, 0, 1, int'(SET_HR),  0, 10, 58, 0};
        vecs[10] = '{0, 1, 0, int'(SET_HR),  0, 10, 58, 0};
        vecs[11] = '{0, 1, 1, int'(SET_HR),  0, 10, 58, 0};
        vecs[12] = '{1, 0, 0, int'(SET_MIN), 0, 10, 58, 0};
        vecs[13] = '{1, 0, 0, int'(LOAD),    1, 10, 58, 0};
        vecs[14] = '{0, 0, 0, int'(RUN),     0, 10, 58, 0};
        vecs[15] = '{0, 0, 1, int'(RUN),     0, 10, 58, 1};
        vecs[16] = '{0, 0, 1, int'(RUN),     0, 10, 58, 0};

        rst = 1; btn_mode = 0; btn_set = 0; btn_inc = 0;
        cur_hours = 0; cur_minutes = 0;
        #1;
        check_all_zero("reset");
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 0;

        cur_hours = 10; cur_minutes = 58;
        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].bm, vecs[i].bs, vecs[i].bi);
            check($sformatf("vec%0d.mode", i), 32'(mode), 32'(vecs[i].exp_mode));
            check($sformatf("vec%0d.flag", i), 32'(set_time_flag), 32'(vecs[i].exp_flag));
            check($sformatf("vec%0d.set_h", i), 32'(set_hours), 32'(vecs[i].exp_h));
            check($sformatf("vec%0d.set_m", i), 32'(set_minutes), 32'(vecs[i].exp_m));
            check($sformatf("vec%0d.en", i), 32'(alarm_en), 32'(vecs[i].exp_en));
        end

        // Wrap 23->0 and 59->0.
        cur_hours = 23; cur_minutes = 59;
        cycle(1, 0, 0); check("wrap.h23", 32'(set_hours), 23);
        cycle(0, 0, 1); check("wrap.h0", 32'(set_hours), 0);
        cycle(1, 0, 0); check("wrap.m59", 32'(set_minutes), 59);
        cycle(0, 0, 1); check("wrap.m0", 32'(set_minutes), 0);
        cycle(1, 0, 0); check("wrap.load", 32'(set_time_flag), 1);
        cycle(0, 0, 0); check("wrap.run", 32'(mode), 32'(RUN));

        // Timeout: 29 idle cycles stay in SET_HR, the 30th returns to RUN.
        cycle(1, 0, 0); check("to.enter", 32'(mode), 32'(SET_HR));
        flag_seen = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            cycle(0, 0, 0);
            if (set_time_flag) flag_seen++;
        end
        check("to.still_edit", 32'(mode), 32'(SET_HR));
        cycle(0, 0, 0);
        if (set_time_flag) flag_seen++;
        check("to.run", 32'(mode), 32'(RUN));
        check("to.no_flag", 32'(flag_seen), 0);

        // Alarm set to 07:30 while the clock shows 07:29.
        cur_hours = 7; cur_minutes = 29;
        cycle(0, 1, 0); check("al.enter", 32'(mode), 32'(AL_HR));
        for (int k = 0; k < 7; k++) cycle(0, 0, 1);
        cycle(1, 0, 0); check("al.min", 32'(mode), 32'(AL_MIN));
        for (int k = 0; k < 30; k++) cycle(0, 0, 1);
        cycle(1, 0, 0);
        check("al.run", 32'(mode), 32'(RUN));
        check("al.en", 32'(alarm_en), 1);
        check("al.h", 32'(alarm_hours), 7);
        check("al.m", 32'(alarm_minutes), 30);
        check("al.quiet", 32'(alarm_ring), 0);
        cur_minutes = 30;
        cycle(0, 0, 0); check("al.ring1", 32'(alarm_ring), 1);
        ring_cnt = 1; ring_at_61 = 1;
        for (int k = 2; k <= 75; k++) begin
            cycle(0, 0, 0);
            if (alarm_ring) ring_cnt++;
            if (k == 61) ring_at_61 = alarm_ring;
        end
        check("al.ring_len", 32'(ring_cnt), 32'(RING_LEN));
        check("al.ring_off61", 32'(ring_at_61), 0);

        // Silence with btn_inc: ring clears, alarm stays armed.
        cur_minutes = 31; cycle(0, 0, 0);
        cur_minutes = 30; cycle(0, 0, 0);
        check("sil.ring", 32'(alarm_ring), 1);
        cycle(0, 0, 1);
        check("sil.cleared", 32'(alarm_ring), 0);
        check("sil.en", 32'(alarm_en), 1);
        check("sil.mode", 32'(mode), 32'(RUN));

        // Reset in the middle of SET_MIN.
        cur_hours = 12; cur_minutes = 0;
        cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 1);
        check("rm.setmin", 32'(mode), 32'(SET_MIN));
        #2 rst = 1;
        #1 check_all_zero("rm");
        model_reset();
        @(negedge clk);
        rst = 0;
        flag_seen = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0);
            if (set_time_flag) flag_seen++;
        end
        check("rm.no_flag", 32'(flag_seen), 0);
        check("rm.run", 32'(mode), 32'(RUN));

        // Randomised run against the reference model.
        for (int n = 0; n < 3000; n++) begin
            dens = ((n / 400) % 2) ? 25 : 5;
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                cur_hours = 5'(m_ah); cur_minutes = 6'(m_am);
            end else if (sel == 3) begin
                cur_hours = 5'($urandom_range(0, 23)); cur_minutes = 6'($urandom_range(0, 59));
            end
            cycle($urandom_range(0, 99) < dens / 3, $urandom_range(0, 99) < dens / 4,
                  $urandom_range(0, 99) < dens);
            check_model(n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
